// File: rtl/alu_seq.sv
`default_nettype none
//==============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle ALU of the Jac1-8 datapath. Arithmetic, logic and
//            shift ops finish in one cycle. MUL (shift-add) and DIV
//            (restoring) iterate one bit per clock behind a start/busy/done
//            handshake. Feeds the status register (alu_status + stat_wr).
// Options  : define ALU_DIV_EN to build the divider; without it op 11 is a
//            NOP and no divider logic exists.
// Revision : 1.0 - initial release
//==============================================================================
module alu_seq #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_STATUS_BITS = 6
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       start,
    input  logic [3:0]                 op,
    input  logic [DATA_WIDTH-1:0]      a,
    input  logic [DATA_WIDTH-1:0]      b,
    input  logic                       carry_in,
    output logic [DATA_WIDTH-1:0]      result,
    output logic [DATA_WIDTH-1:0]      result_hi,
    output logic [NUM_STATUS_BITS-1:0] alu_status,
    output logic                       stat_wr,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int HALF  = DATA_WIDTH / 2;
    localparam int MSB   = DATA_WIDTH - 1;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_WIDTH - 1);

    // op encodings
    localparam logic [3:0] c_op_add       = 4'd0;
    localparam logic [3:0] c_op_adc       = 4'd1;
    localparam logic [3:0] c_op_sub       = 4'd2;
    localparam logic [3:0] c_op_sbc       = 4'd3;
    localparam logic [3:0] c_op_and       = 4'd4;
    localparam logic [3:0] c_op_or        = 4'd5;
    localparam logic [3:0] c_op_xor       = 4'd6;
    localparam logic [3:0] c_op_not       = 4'd7;
    localparam logic [3:0] c_op_shl       = 4'd8;
    localparam logic [3:0] c_op_shr       = 4'd9;
    localparam logic [3:0] c_op_mul       = 4'd10;
    localparam logic [3:0] c_op_div       = 4'd11;
    localparam logic [3:0] c_op_nop_first = 4'd12;

    // status bit positions {E,H,V,N,Z,C}
    localparam int c_flag_c = 0;
    localparam int c_flag_z = 1;
    localparam int c_flag_n = 2;
    localparam int c_flag_v = 3;
    localparam int c_flag_h = 4;
    localparam int c_flag_e = 5;

    // controller states
    localparam logic [1:0] c_state_idle = 2'd0;
    localparam logic [1:0] c_state_iter = 2'd1;
    localparam logic [1:0] c_state_done = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]      r_hi;
    logic [DATA_WIDTH-1:0]      r_lo;
    logic [DATA_WIDTH-1:0]      r_b;
    logic [DATA_WIDTH-1:0]      r_result;
    logic [DATA_WIDTH-1:0]      r_result_hi;
    logic [NUM_STATUS_BITS-1:0] r_status;
    logic                       r_wr;

    logic                       w_is_iter_op;
    logic                       w_is_nop;
    logic                       w_start_iter;
    logic                       w_load_simple;
    logic                       w_load_iter;

    logic                       w_cin;
    logic [DATA_WIDTH:0]        w_sum;
    logic [DATA_WIDTH:0]        w_dif;
    logic [DATA_WIDTH-1:0]      w_simple_res;
    logic [NUM_STATUS_BITS-1:0] w_simple_stat;
    logic                       w_c;
    logic                       w_h;
    logic                       w_v;

    logic [DATA_WIDTH:0]        w_mul_sum;
    logic [DATA_WIDTH-1:0]      w_step_hi;
    logic [DATA_WIDTH-1:0]      w_step_lo;
    logic [DATA_WIDTH-1:0]      w_iter_res;
    logic [DATA_WIDTH-1:0]      w_iter_hi;
    logic [NUM_STATUS_BITS-1:0] w_iter_stat;

`ifdef ALU_DIV_EN
    logic                       w_div_sel;
    logic                       r_is_div;
    logic [DATA_WIDTH-1:0]      r_a;
    logic [DATA_WIDTH:0]        w_div_shift;
    logic [DATA_WIDTH:0]        w_div_trial;

    assign w_div_sel    = (op == c_op_div);
    assign w_is_iter_op = (op == c_op_mul) || w_div_sel;
    assign w_is_nop     = (op >= c_op_nop_first);
`else
    assign w_is_iter_op = (op == c_op_mul);
    assign w_is_nop     = (op == c_op_div) || (op >= c_op_nop_first);
`endif

    assign busy    = (r_state != c_state_idle);
    assign done    = (r_state == c_state_done);
    assign stat_wr = r_wr;

    assign result     = r_result;
    assign result_hi  = r_result_hi;
    assign alu_status = r_status;

    // Single-cycle datapath: computes result and flags straight from the inputs
    always_comb begin
        w_cin        = carry_in & ((op == c_op_adc) || (op == c_op_sbc));
        w_sum        = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, w_cin};
        w_dif        = {1'b0, a} - {1'b0, b} - {{DATA_WIDTH{1'b0}}, w_cin};
        w_simple_res = '0;
        w_c          = 1'b0;
        w_h          = 1'b0;
        w_v          = 1'b0;
        case (op)
            c_op_add, c_op_adc: begin
                w_simple_res = w_sum[MSB:0];
                w_c          = w_sum[DATA_WIDTH];
                // carry into the upper nibble recovered from the sum bit
                w_h          = a[HALF] ^ b[HALF] ^ w_sum[HALF];
                w_v          = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            c_op_sub, c_op_sbc: begin
                w_simple_res = w_dif[MSB:0];
                w_c          = w_dif[DATA_WIDTH];
                // borrow into the upper nibble recovered from the difference bit
                w_h          = a[HALF] ^ b[HALF] ^ w_dif[HALF];
                w_v          = (a[MSB] != b[MSB]) && (w_dif[MSB] != a[MSB]);
            end
            c_op_and: w_simple_res = a & b;
            c_op_or:  w_simple_res = a | b;
            c_op_xor: w_simple_res = a ^ b;
            c_op_not: w_simple_res = ~a;
            c_op_shl: begin
                w_simple_res = {a[DATA_WIDTH-2:0], 1'b0};
                w_c          = a[MSB];
            end
            c_op_shr: begin
                w_simple_res = {1'b0, a[MSB:1]};
                w_c          = a[0];
            end
            default: ;
        endcase
        w_simple_stat           = '0;
        w_simple_stat[c_flag_c] = w_c;
        w_simple_stat[c_flag_z] = (w_simple_res == '0);
        w_simple_stat[c_flag_n] = w_simple_res[MSB];
        w_simple_stat[c_flag_v] = w_v;
        w_simple_stat[c_flag_h] = w_h;
    end

    // One iteration of shift-add multiply (or restoring divide) on the working pair
    always_comb begin
        w_mul_sum = {1'b0, r_hi};
        if (r_lo[0]) begin
            w_mul_sum = {1'b0, r_hi} + {1'b0, r_b};
        end
        w_step_hi = w_mul_sum[DATA_WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_lo[MSB:1]};
`ifdef ALU_DIV_EN
        // remainder in r_hi, dividend shifts out of r_lo while quotient shifts in
        w_div_shift = {r_hi, r_lo[MSB]};
        w_div_trial = w_div_shift - {1'b0, r_b};
        if (r_is_div) begin
            if (!w_div_trial[DATA_WIDTH]) begin
                w_step_hi = w_div_trial[MSB:0];
                w_step_lo = {r_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[MSB:0];
                w_step_lo = {r_lo[DATA_WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Final MUL/DIV outputs and flags, taken from the last iteration step
    always_comb begin
        w_iter_res              = w_step_lo;
        w_iter_hi               = w_step_hi;
        w_iter_stat             = '0;
        w_iter_stat[c_flag_z]   = ({w_step_hi, w_step_lo} == '0);
        w_iter_stat[c_flag_n]   = w_step_hi[MSB];
        w_iter_stat[c_flag_v]   = (w_step_hi != '0);
`ifdef ALU_DIV_EN
        if (r_is_div) begin
            w_iter_stat = '0;
            if (r_b == '0) begin
                // divide by zero: saturated quotient, dividend kept as remainder
                w_iter_res            = '1;
                w_iter_hi             = r_a;
                w_iter_stat[c_flag_e] = 1'b1;
                w_iter_stat[c_flag_n] = 1'b1;
            end else begin
                w_iter_stat[c_flag_z] = (w_step_lo == '0);
                w_iter_stat[c_flag_n] = w_step_lo[MSB];
            end
        end
`endif
    end

    // Next-state and load strobes; start is honoured only in IDLE
    always_comb begin
        w_state_nxt   = r_state;
        w_start_iter  = 1'b0;
        w_load_simple = 1'b0;
        w_load_iter   = 1'b0;
        case (r_state)
            c_state_idle: begin
                if (start) begin
                    if (w_is_iter_op) begin
                        w_state_nxt  = c_state_iter;
                        w_start_iter = 1'b1;
                    end else begin
                        w_state_nxt   = c_state_done;
                        w_load_simple = !w_is_nop;
                    end
                end
            end
            c_state_iter: begin
                if (r_cnt == c_last_iter) begin
                    w_state_nxt = c_state_done;
                    w_load_iter = 1'b1;
                end
            end
            c_state_done: w_state_nxt = c_state_idle;
            default:      w_state_nxt = c_state_idle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= c_state_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture and iteration working registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
`ifdef ALU_DIV_EN
            r_a      <= '0;
            r_is_div <= 1'b0;
`endif
        end else if (w_start_iter) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= a;
            r_b      <= b;
`ifdef ALU_DIV_EN
            r_a      <= a;
            r_is_div <= w_div_sel;
`endif
        end else if (r_state == c_state_iter) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
        end
    end

    // Visible outputs change only on entry to DONE; NOPs leave them untouched
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_status    <= '0;
            r_wr        <= 1'b0;
        end else begin
            r_wr <= w_load_simple | w_load_iter;
            if (w_load_simple) begin
                r_result    <= w_simple_res;
                r_result_hi <= '0;
                r_status    <= w_simple_stat;
            end else if (w_load_iter) begin
                r_result    <= w_iter_res;
                r_result_hi <= w_iter_hi;
                r_status    <= w_iter_stat;
            end
        end
    end

endmodule
`default_nettype wire
